// File: rtl/alu_issue_unit_if.sv
// Handshake, ALU drive and debug-read bundle for alu_issue_unit.
// The slave modport is the issue unit; the master modport is the instruction source/ALU side.
interface alu_issue_unit_if #(
  parameter int unsigned DW = 8
);
  logic          instr_valid;
  logic          instr_ready;
  logic [8:0]    instr;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          done;
  logic          illegal;
  logic          busy;
  logic [2:0]    dbg_raddr;
  logic [DW-1:0] dbg_rdata;

  modport slave (
    input  instr_valid, instr, alu_result, dbg_raddr,
    output instr_ready, alu_op, alu_a, alu_b, done, illegal, busy, dbg_rdata
  );

  modport master (
    output instr_valid, instr, alu_result, dbg_raddr,
    input  instr_ready, alu_op, alu_a, alu_b, done, illegal, busy, dbg_rdata
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Four-state issue/writeback sequencer in front of a combinational 8-bit ALU.
// Owns the 8x8 register file; every instruction takes IDLE->DECODE->EXEC->WB.
module alu_issue_unit #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 8
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;
  typedef enum logic [1:0] {ClsNone, ClsLdi, ClsAlu, ClsIllegal} op_class_e;

  state_e    state_q, state_d;
  op_class_e cls_q;
  logic [8:0]    instr_q;
  logic [DW-1:0] op_a_q, op_b_q, result_q;
  logic [DW-1:0] rf_q [NREGS];

  logic [2:0]    opc;
  logic [AW-1:0] rd, rs;
  logic [DW-1:0] imm_ext;
  logic          accept;
  op_class_e     cls_dec;

  assign opc     = instr_q[8:6];
  assign rd      = instr_q[5:3];
  assign rs      = instr_q[2:0];
  assign imm_ext = {{(DW-3){1'b0}}, instr_q[2:0]};
  assign accept  = (state_q == StIdle) && bus.instr_valid;

  always_comb begin
    cls_dec = ClsAlu;
    unique case (opc)
      3'b000:  cls_dec = ClsNone;
      3'b001:  cls_dec = ClsLdi;
      3'b010:  cls_dec = ClsIllegal;
      default: cls_dec = ClsAlu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.instr_ready  = 1'b0;
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;
    bus.busy         = 1'b1;
    bus.alu_op       = '0;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    unique case (state_q)
      StIdle: begin
        bus.instr_ready = 1'b1;
        bus.busy        = 1'b0;
        if (bus.instr_valid) state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        // ldi, nop and reserved opcodes leave the ALU inputs quiet
        if (cls_q == ClsAlu) begin
          bus.alu_op = {1'b0, opc};
          bus.alu_a  = op_a_q;
          bus.alu_b  = op_b_q;
        end
        state_d = StWb;
      end
      StWb: begin
        bus.done    = 1'b1;
        bus.illegal = (cls_q == ClsIllegal);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      cls_q    <= ClsNone;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      if (accept) instr_q <= bus.instr;
      if (state_q == StDecode) begin
        cls_q  <= cls_dec;
        op_a_q <= rf_q[rd];
        // inc takes its B operand from the immediate field, not a register
        op_b_q <= (opc == 3'b100) ? imm_ext : rf_q[rs];
      end
      if (state_q == StExec) begin
        result_q <= (cls_q == ClsLdi) ? imm_ext : bus.alu_result;
      end
      if (state_q == StWb && (cls_q == ClsLdi || cls_q == ClsAlu)) begin
        rf_q[rd] <= result_q;
      end
    end
  end

  assign bus.dbg_rdata = rf_q[bus.dbg_raddr];

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Multi-cycle issue/writeback sequencer that sits on the initiator side of the combinational 8-bit ALU.
- Accepts 9-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x8 register file, drives the ALU opcode and operand inputs, then captures the ALU result and writes it back.
- Owns all architectural register state for the datapath.

Parameters:
- NREGS, 8, number of 8-bit registers. Fixed at 8; the instruction encodes register indices in 3 bits.
- DW, 8, data width. Matches the ALU operand and result width.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- INSTR_VALID  input  1  instruction offered.
- INSTR_READY  output  1  unit can accept an instruction this cycle.
- INSTR  input  9  [8:6] opcode, [5:3] rd, [2:0] rs or imm3.
- ALU_OP  output  4  opcode to the ALU.
- ALU_A  output  8  operand A to the ALU.
- ALU_B  output  8  operand B to the ALU.
- ALU_RESULT  input  8  combinational ALU output.
- DONE  output  1  one-cycle pulse: instruction retired.
- ILLEGAL  output  1  one-cycle pulse coincident with DONE for a reserved opcode.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- DBG_RADDR  input  3  debug register index.
- DBG_RDATA  output  8  combinational read of rf[DBG_RADDR].

Behaviour:
- Reset (RESET_N low, async, any state):
  - FSM goes to IDLE and all 8 registers clear to 0.
  - Latched instruction, operand and result registers clear to 0.
  - Outputs: INSTR_READY=1, DONE=0, ILLEGAL=0, BUSY=0, ALU_OP=0, ALU_A=0, ALU_B=0.
  - A reset during any state aborts the instruction; no writeback occurs.
- Opcode map:
  - 000 nop: no write.
  - 001 ldi: rd = {5'b0, imm3}; the ALU is not used.
  - 010: reserved, treated as illegal; no write.
  - 011 xor: rd = rd ^ rs.
  - 100 inc: rd = rd + {5'b0, imm3}.
  - 101 shl: rd = rd << rs.
  - 110 shr: rd = rd >>> rs.
  - 111 and: rd = rd & rs.
- ALU drive, only in EXEC:
  - ALU_OP = {1'b0, opcode}.
  - ALU_A = rf[rd].
  - For opcodes 011, 101, 110, 111: ALU_B = rf[rs] (full 8 bits).
  - For 100: ALU_B = {5'b0, imm3}.
  - ALU_RESULT is taken as-is (8-bit, carry discarded); the unit does no arithmetic of its own.
  - Outside EXEC, ALU_OP, ALU_A and ALU_B are 0.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: INSTR_READY=1. A handshake completes on an edge with INSTR_VALID & INSTR_READY; INSTR is latched and the FSM moves to DECODE.
  - DECODE: latch rf[rd] and rf[rs] into operand registers, plus the decoded operation class.
  - EXEC: drive the ALU from the operand registers. Capture ALU_RESULT into the result register at the end of EXEC; for ldi, capture the zero-extended imm instead.
  - WB: DONE=1. ILLEGAL=1 if opcode is 010. Write the result register to rf[rd] at the end of WB only for 001 and 011–111.
  - Every opcode, including nop and illegal, traverses all four states.
- Latency and throughput:
  - Handshake at edge T; DECODE in cycle T+1, EXEC in T+2, WB/DONE in T+3.
  - INSTR_READY is high again in T+4.
  - Throughput is one instruction per 4 cycles.
- Handshake rules:
  - INSTR_READY=0 in DECODE/EXEC/WB; INSTR is ignored there even if INSTR_VALID is high.
  - No skid buffer: the upstream holds INSTR_VALID and INSTR until accepted.
- Hazards: none, because operands are read in DECODE after the previous WB has written.
- rd == rs is legal: both operands are the same old value (e.g. xor r2,r2 gives 0).
- DBG_RDATA is a combinational register-file read; a WB write is visible from the cycle after WB.

Test Plan:
- Reset, then ldi r1,5 and ldi r2,3 -> DONE at T+3 for each; DBG r1=5, r2=3; ALU_OP stays 0 throughout.
- Then xor r1,r2 (INSTR=9'b011_001_010) -> in EXEC ALU_OP=3, ALU_A=5, ALU_B=3; with ALU returning 6, DBG r1=6 after WB.
- inc r1,7 with r1=6 -> EXEC ALU_OP=4, ALU_A=6, ALU_B=7; r1=13. inc with r1=250, imm 7, ALU returning 1 -> r1=1 (wrap stored as returned).
- Hold INSTR_VALID=1 with a new instruction from T+1 to T+4 -> INSTR_READY=0 in T+1..T+3, accepted at the T+4 edge; exactly one DONE per instruction.
- Opcode 010 to r4 holding 9 -> DONE and ILLEGAL both pulse in T+3; r4 stays 9; next instruction is accepted normally.
- Assert RESET_N=0 mid-EXEC of and r3,r5 -> outputs return to reset values immediately; no DONE; all registers read 0; INSTR_READY=1 after release.
